// File: rtl/glove_tracker.sv
// glove_tracker: thresholds a raw RGB stream, accumulates centroid sums per frame
// and publishes the glove position. Define GLOVE_BBOX_EN to add bounding-box outputs.
module glove_tracker #(
  parameter logic [7:0]  R_MIN     = 8'hC0,
  parameter logic [7:0]  G_MAX     = 8'h40,
  parameter logic [7:0]  B_MAX     = 8'h40,
  parameter int unsigned MIN_COUNT = 64
) (
  input  logic        vclock,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic [23:0] pixel,
  output logic [10:0] glove_x,
  output logic [9:0]  glove_y,
  output logic        glove_found,
  output logic        pos_valid,
  output logic        overrun
`ifdef GLOVE_BBOX_EN
  ,
  output logic [10:0] bbox_xmin,
  output logic [10:0] bbox_xmax,
  output logic [9:0]  bbox_ymin,
  output logic [9:0]  bbox_ymax
`endif
);

  // state | meaning
  // IDLE  | waiting for a frame end (vsync falling edge)
  // CHECK | latched match count compared against MIN_COUNT
  // DIV   | one restoring-divide step per cycle, iter counts down 29..0
  // DONE  | publish centroid and raise pos_valid

  localparam logic [19:0] MIN_CNT = 20'(MIN_COUNT);
  localparam logic [10:0] COL_MAX = 11'd1023;
  localparam logic [9:0]  ROW_MAX = 10'd767;

  typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;
  state_t state, state_nxt;

  logic        hs_r, vs_r, bl_r, hs_d, vs_d, bl_d;
  logic [23:0] px_r;
  logic        hs_fall, vs_fall, bl_rise, match;

  logic [10:0] col;
  logic [9:0]  row;
  logic        line_act;
  logic [29:0] sum_x, sum_y;
  logic [19:0] cnt;

  logic [29:0] num_x, num_y;
  logic [19:0] rem_x, rem_y, den;
  logic [4:0]  iter;
  logic [20:0] shx, shy;
  logic [19:0] dfx, dfy;
  logic        gex, gey;
  logic        pv_nxt, found_nxt, publish;

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      {hs_r, vs_r, bl_r, hs_d, vs_d, bl_d} <= '0;
      px_r <= '0;
    end else begin
      hs_r <= hsync;
      vs_r <= vsync;
      bl_r <= blank;
      px_r <= pixel;
      hs_d <= hs_r;
      vs_d <= vs_r;
      bl_d <= bl_r;
    end
  end

  assign hs_fall = hs_d & ~hs_r;
  assign vs_fall = vs_d & ~vs_r;
  assign bl_rise = ~bl_d & bl_r;
  assign match   = ~bl_r && (px_r[23:16] >= R_MIN) && (px_r[15:8] <= G_MAX)
                   && (px_r[7:0] <= B_MAX);

  // Frame end clears the accumulators even when the frame itself is dropped.
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      col      <= '0;
      row      <= '0;
      line_act <= 1'b0;
      sum_x    <= '0;
      sum_y    <= '0;
      cnt      <= '0;
    end else begin
      if (hs_fall)
        col <= '0;
      else if (!bl_r && col != COL_MAX)
        col <= col + 11'd1;

      if (vs_fall) begin
        row      <= '0;
        line_act <= 1'b0;
      end else if (bl_rise) begin
        line_act <= 1'b0;
        if (line_act && row != ROW_MAX)
          row <= row + 10'd1;
      end else if (!bl_r) begin
        line_act <= 1'b1;
      end

      if (vs_fall) begin
        sum_x <= '0;
        sum_y <= '0;
        cnt   <= '0;
      end else if (match) begin
        sum_x <= sum_x + {19'd0, col};
        sum_y <= sum_y + {20'd0, row};
        cnt   <= cnt + 20'd1;
      end
    end
  end

  assign shx = {rem_x, num_x[29]};
  assign shy = {rem_y, num_y[29]};
  assign gex = shx >= {1'b0, den};
  assign gey = shy >= {1'b0, den};
  assign dfx = shx[19:0] - den;
  assign dfy = shy[19:0] - den;

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pv_nxt    = 1'b0;
    found_nxt = glove_found;
    publish   = 1'b0;
    case (state)
      IDLE:  if (vs_fall) state_nxt = CHECK;
      CHECK: begin
        if (den == 20'd0 || den < MIN_CNT) begin
          state_nxt = IDLE;
          pv_nxt    = 1'b1;
          found_nxt = 1'b0;
        end else begin
          state_nxt = DIV;
        end
      end
      DIV:   if (iter == 5'd0) state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        pv_nxt    = 1'b1;
        found_nxt = 1'b1;
        publish   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // num_x/num_y hold the dividends and fill up with quotient bits as they shift.
  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      num_x       <= '0;
      num_y       <= '0;
      rem_x       <= '0;
      rem_y       <= '0;
      den         <= '0;
      iter        <= '0;
      glove_x     <= '0;
      glove_y     <= '0;
      glove_found <= 1'b0;
      pos_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun     <= vs_fall && (state != IDLE);
      pos_valid   <= pv_nxt;
      glove_found <= found_nxt;
      if (vs_fall && state == IDLE) begin
        num_x <= sum_x;
        num_y <= sum_y;
        den   <= cnt;
      end else if (state == CHECK) begin
        rem_x <= '0;
        rem_y <= '0;
        iter  <= 5'd29;
      end else if (state == DIV) begin
        num_x <= {num_x[28:0], gex};
        num_y <= {num_y[28:0], gey};
        rem_x <= gex ? dfx : shx[19:0];
        rem_y <= gey ? dfy : shy[19:0];
        iter  <= iter - 5'd1;
      end
      if (publish) begin
        glove_x <= num_x[10:0];
        glove_y <= (num_y > {20'd0, ROW_MAX}) ? ROW_MAX : num_y[9:0];
      end
    end
  end

`ifdef GLOVE_BBOX_EN
  logic [10:0] run_xmin, run_xmax, op_xmin, op_xmax;
  logic [9:0]  run_ymin, run_ymax, op_ymin, op_ymax;

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      run_xmin  <= COL_MAX;
      run_xmax  <= '0;
      run_ymin  <= ROW_MAX;
      run_ymax  <= '0;
      op_xmin   <= '0;
      op_xmax   <= '0;
      op_ymin   <= '0;
      op_ymax   <= '0;
      bbox_xmin <= '0;
      bbox_xmax <= '0;
      bbox_ymin <= '0;
      bbox_ymax <= '0;
    end else begin
      if (vs_fall) begin
        run_xmin <= COL_MAX;
        run_xmax <= '0;
        run_ymin <= ROW_MAX;
        run_ymax <= '0;
        if (state == IDLE) begin
          op_xmin <= run_xmin;
          op_xmax <= run_xmax;
          op_ymin <= run_ymin;
          op_ymax <= run_ymax;
        end
      end else if (match) begin
        if (col < run_xmin) run_xmin <= col;
        if (col > run_xmax) run_xmax <= col;
        if (row < run_ymin) run_ymin <= row;
        if (row > run_ymax) run_ymax <= row;
      end
      if (publish) begin
        bbox_xmin <= op_xmin;
        bbox_xmax <= op_xmax;
        bbox_ymin <= op_ymin;
        bbox_ymax <= op_ymax;
      end
    end
  end
`endif

endmodule

// File: tb/tb_glove_tracker.sv
// tb_glove_tracker: drives synthetic video frames into two glove_tracker instances
// (MIN_COUNT 64 and 1) and checks every published result against a frame-level model.
`timescale 1ns/1ps
module tb_glove_tracker;

  localparam int M_BLACK = 0, M_SQUARE = 1, M_FIFTY = 2, M_C040 = 3,
                 M_C041 = 4, M_RAND = 5, M_CORNER = 6;

  logic vclock = 1'b0;
  always #5 vclock = ~vclock;

  logic        reset_n, hsync, vsync, blank;
  logic [23:0] pixel;
  logic [10:0] gx0, gx1;
  logic [9:0]  gy0, gy1;
  logic        gf0, gf1, pv0, pv1, ov0, ov1;
`ifdef GLOVE_BBOX_EN
  logic [10:0] bxn0, bxx0, bxn1, bxx1;
  logic [9:0]  byn0, byx0, byn1, byx1;
`endif

  glove_tracker u_main (
    .vclock(vclock), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
    .blank(blank), .pixel(pixel), .glove_x(gx0), .glove_y(gy0),
    .glove_found(gf0), .pos_valid(pv0), .overrun(ov0)
`ifdef GLOVE_BBOX_EN
    , .bbox_xmin(bxn0), .bbox_xmax(bxx0), .bbox_ymin(byn0), .bbox_ymax(byx0)
`endif
  );

  glove_tracker #(.MIN_COUNT(1)) u_small (
    .vclock(vclock), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
    .blank(blank), .pixel(pixel), .glove_x(gx1), .glove_y(gy1),
    .glove_found(gf1), .pos_valid(pv1), .overrun(ov1)
`ifdef GLOVE_BBOX_EN
    , .bbox_xmin(bxn1), .bbox_xmax(bxx1), .bbox_ymin(byn1), .bbox_ymax(byx1)
`endif
  );

  typedef struct {
    int cyc; int x; int y; int f; int bxn; int bxx; int byn; int byx;
  } res_t;

  res_t   cq0[$], cq1[$], eq0[$], eq1[$];
  int     cyc = 0, ov_cnt0 = 0, ov_cnt1 = 0, exp_ov = 0;
  int     n_assert = 0, n_fail = 0;
  longint m_sx, m_sy, m_cnt;
  int     m_xmin, m_xmax, m_ymin, m_ymax;
  int     e_x[2], e_y[2], e_f[2], e_bxn[2], e_bxx[2], e_byn[2], e_byx[2];
  int     min_cnt[2] = '{64, 1};
  int     rand_w = 8;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, want);
    end
  endtask

  task automatic tick();
    res_t c;
    @(posedge vclock);
    #1;
    cyc++;
    if (pv0 === 1'b1) begin
      c = '{cyc, int'(gx0), int'(gy0), int'(gf0), 0, 0, 0, 0};
`ifdef GLOVE_BBOX_EN
      c.bxn = int'(bxn0); c.bxx = int'(bxx0); c.byn = int'(byn0); c.byx = int'(byx0);
`endif
      cq0.push_back(c);
    end
    if (pv1 === 1'b1) begin
      c = '{cyc, int'(gx1), int'(gy1), int'(gf1), 0, 0, 0, 0};
`ifdef GLOVE_BBOX_EN
      c.bxn = int'(bxn1); c.bxx = int'(bxx1); c.byn = int'(byn1); c.byx = int'(byx1);
`endif
      cq1.push_back(c);
    end
    if (ov0 === 1'b1) ov_cnt0++;
    if (ov1 === 1'b1) ov_cnt1++;
  endtask

  task automatic drive(logic h, logic v, logic b, logic [23:0] p);
    hsync = h; vsync = v; blank = b; pixel = p;
  endtask

  task automatic idle(int n);
    drive(1'b1, 1'b1, 1'b1, 24'h0);
    repeat (n) tick();
  endtask

  task automatic model_clear();
    m_sx = 0; m_sy = 0; m_cnt = 0;
    m_xmin = 1023; m_xmax = 0; m_ymin = 767; m_ymax = 0;
  endtask

  // One active pixel at logical coordinate (x, y); the model clips to the frame.
  task automatic px(int x, int y, logic [23:0] c);
    int xs, ys;
    drive(1'b1, 1'b1, 1'b0, c);
    tick();
    xs = (x > 1023) ? 1023 : x;
    ys = (y > 767) ? 767 : y;
    if (c[23:16] >= 8'hC0 && c[15:8] <= 8'h40 && c[7:0] <= 8'h40) begin
      m_sx += xs; m_sy += ys; m_cnt++;
      if (xs < m_xmin) m_xmin = xs;
      if (xs > m_xmax) m_xmax = xs;
      if (ys < m_ymin) m_ymin = ys;
      if (ys > m_ymax) m_ymax = ys;
    end
  endtask

  function automatic logic [23:0] color_at(int mode, int x, int y);
    case (mode)
      M_SQUARE: return (x >= 100 && x <= 115 && y >= 200 && y <= 215) ? 24'hFF0000 : 24'h0;
      M_FIFTY:  return 24'hFF0000;
      M_C040:   return 24'hC04040;
      M_C041:   return 24'hC04141;
      M_RAND:   return {8'($urandom_range(176, 255)), 8'($urandom_range(0, 96)),
                        8'($urandom_range(0, 96))};
      M_CORNER: return (x == 1028 && y == 770) ? 24'hFF0000 : 24'h0;
      default:  return 24'h0;
    endcase
  endfunction

  function automatic int width_at(int mode, int y);
    case (mode)
      M_SQUARE:       return (y >= 200) ? 116 : 1;
      M_FIFTY:        return 10;
      M_C040, M_C041: return 8;
      M_RAND:         return rand_w;
      M_CORNER:       return (y == 770) ? 1030 : 1;
      default:        return 4;
    endcase
  endfunction

  task automatic send_line(int mode, int y, int w);
    drive(1'b0, 1'b1, 1'b1, 24'h0); tick(); tick();
    drive(1'b1, 1'b1, 1'b1, 24'h0); tick(); tick();
    for (int x = 0; x < w; x++) px(x, y, color_at(mode, x, y));
    drive(1'b1, 1'b1, 1'b1, 24'h0); tick(); tick();
  endtask

  task automatic send_frame(int mode, int nlines);
    for (int y = 0; y < nlines; y++) send_line(mode, y, width_at(mode, y));
  endtask

  // kind 0: normal frame end, 1: dropped (divider busy), 2: result abandoned by reset.
  // Expected result cycle counts from the cycle vsync is driven low: one input
  // register, then 2 cycles to a miss or 33 to a hit.
  task automatic frame_end(int kind);
    res_t e;
    int   lat;
    if (kind == 0) begin
      for (int d = 0; d < 2; d++) begin
        if (m_cnt > 0 && m_cnt >= longint'(min_cnt[d])) begin
          e_x[d] = int'(m_sx / m_cnt);
          e_y[d] = int'(m_sy / m_cnt);
          if (e_y[d] > 767) e_y[d] = 767;
          e_f[d] = 1;
          e_bxn[d] = m_xmin; e_bxx[d] = m_xmax; e_byn[d] = m_ymin; e_byx[d] = m_ymax;
          lat = 1 + 33;
        end else begin
          e_f[d] = 0;
          lat = 1 + 2;
        end
        e = '{cyc + lat, e_x[d], e_y[d], e_f[d], e_bxn[d], e_bxx[d], e_byn[d], e_byx[d]};
        if (d == 0) eq0.push_back(e);
        else        eq1.push_back(e);
      end
    end else if (kind == 1) begin
      exp_ov++;
    end
    model_clear();
    drive(1'b1, 1'b0, 1'b1, 24'h0); tick(); tick();
    drive(1'b1, 1'b1, 1'b1, 24'h0);
  endtask

  task automatic check_one(string tag, res_t c, res_t e);
    chk({tag, "_latency"}, c.cyc, e.cyc);
    chk({tag, "_x"}, c.x, e.x);
    chk({tag, "_y"}, c.y, e.y);
    chk({tag, "_found"}, c.f, e.f);
`ifdef GLOVE_BBOX_EN
    chk({tag, "_bxmin"}, c.bxn, e.bxn);
    chk({tag, "_bxmax"}, c.bxx, e.bxx);
    chk({tag, "_bymin"}, c.byn, e.byn);
    chk({tag, "_bymax"}, c.byx, e.byx);
`endif
  endtask

  task automatic check_results(string tag);
    chk({tag, "_count_main"}, cq0.size(), eq0.size());
    chk({tag, "_count_small"}, cq1.size(), eq1.size());
    while (cq0.size() > 0 && eq0.size() > 0) check_one({tag, "_main"}, cq0.pop_front(), eq0.pop_front());
    while (cq1.size() > 0 && eq1.size() > 0) check_one({tag, "_small"}, cq1.pop_front(), eq1.pop_front());
    cq0.delete(); cq1.delete(); eq0.delete(); eq1.delete();
    chk({tag, "_overrun_main"}, ov_cnt0, exp_ov);
    chk({tag, "_overrun_small"}, ov_cnt1, exp_ov);
  endtask

  task automatic run_frame(string tag, int mode, int nlines);
    send_frame(mode, nlines);
    frame_end(0);
    idle(40);
    check_results(tag);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_x_main"}, gx0, 0);
    chk({tag, "_y_main"}, gy0, 0);
    chk({tag, "_found_main"}, gf0, 0);
    chk({tag, "_pv_main"}, pv0, 0);
    chk({tag, "_ovr_main"}, ov0, 0);
    chk({tag, "_x_small"}, gx1, 0);
    chk({tag, "_y_small"}, gy1, 0);
    chk({tag, "_found_small"}, gf1, 0);
`ifdef GLOVE_BBOX_EN
    chk({tag, "_bxmax_small"}, bxx1, 0);
    chk({tag, "_bymax_small"}, byx1, 0);
`endif
  endtask

  task automatic clear_expect();
    for (int d = 0; d < 2; d++) begin
      e_x[d] = 0; e_y[d] = 0; e_f[d] = 0;
      e_bxn[d] = 0; e_bxx[d] = 0; e_byn[d] = 0; e_byx[d] = 0;
    end
    cq0.delete(); cq1.delete(); eq0.delete(); eq1.delete();
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 24'h0);
    model_clear();
    clear_expect();
    repeat (3) tick();
    chk_zero("por");
    reset_n = 1'b1;
    tick();

    run_frame("black", M_BLACK, 8);
    run_frame("square", M_SQUARE, 216);
    run_frame("fifty", M_FIFTY, 5);
    run_frame("c04040", M_C040, 8);
    run_frame("c04141", M_C041, 8);
    for (int i = 0; i < 3; i++) begin
      rand_w = $urandom_range(20, 60);
      run_frame("random", M_RAND, $urandom_range(10, 30));
    end

    // Second frame end arrives 10 cycles after the first, with a few matched
    // pixels in between that must not leak into the following frame.
    send_frame(M_SQUARE, 216);
    frame_end(0);
    drive(1'b0, 1'b1, 1'b1, 24'h0); tick(); tick();
    drive(1'b1, 1'b1, 1'b1, 24'h0); tick(); tick();
    for (int x = 0; x < 3; x++) px(x, 0, 24'hFF0000);
    idle(1);
    frame_end(1);
    idle(40);
    check_results("overrun");
    run_frame("after_overrun", M_FIFTY, 5);

    run_frame("corner", M_CORNER, 771);

    // Reset in the middle of a division: outputs drop at once, result never appears.
    send_frame(M_SQUARE, 216);
    frame_end(2);
    idle(8);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("mid_div_reset");
    tick();
    tick();
    clear_expect();
    reset_n = 1'b1;
    tick();
    run_frame("post_reset", M_BLACK, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/glove_tracker.md
Name: glove_tracker

Overview:
- Consumes a raw video stream (hsync/vsync/blank/24-bit pixel, same timing as the catch_game output) and locates one coloured glove per frame.
- Recovers the pixel column/row from sync and blank, thresholds each active pixel against a colour window, and accumulates the centroid sums.
- At frame end, divides the sums sequentially and publishes the glove position with a one-cycle valid strobe.
- Sits upstream of the coordinate/ball logic and feeds the rel_glove x/y inputs.

Parameters:
- R_MIN, 8'hC0, minimum red component for a glove pixel (inclusive).
- G_MAX, 8'h40, maximum green component (inclusive).
- B_MAX, 8'h40, maximum blue component (inclusive).
- MIN_COUNT, 64, minimum matched pixels per frame for a valid detection.

Ports:
- vclock  in  1  pixel clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- hsync  in  1  horizontal sync, active low.
- vsync  in  1  vertical sync, active low.
- blank  in  1  1 = non-active pixel.
- pixel  in  24  r=23:16, g=15:8, b=7:0.
- glove_x  out  11  centroid column, 0..1023.
- glove_y  out  10  centroid row, 0..767.
- glove_found  out  1  last completed frame met MIN_COUNT.
- pos_valid  out  1  one-cycle pulse when glove_x/glove_y/glove_found update.
- overrun  out  1  one-cycle pulse when a frame end is dropped because the divider is busy.

Behaviour:
- Reset (async assert, sync release): all counters, accumulators and outputs = 0; FSM = IDLE.
- Input register stage:
  - hsync, vsync, blank, pixel registered once.
  - Edges detected on the registered copies against a second delayed copy.
- Column counter col[10:0]:
  - Cleared on an hsync falling edge.
  - Increments after each cycle with blank=0.
  - Saturates at 1023.
- Row counter row[9:0]:
  - Increments on a blank rising edge if the line just ended had ≥1 active pixel.
  - Cleared on a vsync falling edge.
  - Saturates at 767.
- Match: blank=0 && r>=R_MIN && g<=G_MAX && b<=B_MAX.
- On a match (same cycle, registered):
  - sum_x[29:0] += col.
  - sum_y[29:0] += row.
  - cnt[19:0] += 1.
- Accumulator width 30 bits is sufficient: max 1023*786432 < 2^30. No wrap handling required.
- Frame end = vsync falling edge:
  - If FSM is IDLE: latch sum_x, sum_y, cnt into divider operands; clear the accumulators in the same cycle; FSM -> CHECK.
  - If FSM is not IDLE: the frame is discarded, the accumulators are still cleared, and overrun pulses for 1 cycle.
- FSM states:
  - IDLE: waits for frame end.
  - CHECK (1 cycle): if cnt < MIN_COUNT, set glove_found=0, hold glove_x/glove_y, pulse pos_valid, -> IDLE. Otherwise -> DIV.
  - DIV (30 cycles): two parallel restoring dividers, sum_x/cnt and sum_y/cnt, one quotient bit per cycle MSB first, 5-bit iteration counter.
  - DONE (1 cycle): glove_x = quot_x[10:0]; glove_y = quot_y[9:0] clamped to 767; glove_found=1; pos_valid=1; -> IDLE.
- Latency: frame end -> pos_valid = 2 cycles for a miss, 33 cycles for a hit (latch, CHECK, 30×DIV, DONE).
- Quotients truncate (floor).
- cnt=0 always takes the miss path, so no divide-by-zero is possible.
- Pixels arriving during DIV accumulate normally into the next frame's sums.
- reset_n asserted mid-division: the division is abandoned and all outputs return to 0.

Optional Feature:
- Macro: GLOVE_BBOX_EN.
- When defined:
  - Adds outputs bbox_xmin[10:0], bbox_xmax[10:0], bbox_ymin[9:0], bbox_ymax[9:0].
  - Tracked per frame over matched pixels; running min initialised to 1023/767 and max to 0 at each frame end.
  - Published together with glove_x/glove_y on pos_valid.
  - On a miss: outputs are held, same as the centroid.
- When undefined: the ports and their tracking registers are absent; everything else is identical.

Test Plan:
- Reset: assert reset_n=0 mid-frame -> all outputs 0 immediately; with no matches, the first frame end gives pos_valid with glove_found=0 after 2 cycles.
- 16×16 pure red square (FF0000) at cols 100..115, rows 200..215, black elsewhere -> pos_valid 33 cycles after vsync fall; glove_x=107, glove_y=207, glove_found=1.
- Only 50 matching pixels (< MIN_COUNT 64) -> glove_found=0, glove_x/glove_y hold previous values 107/207.
- Colour boundary: pixel C04040 matches and C04141 does not -> a 64-pixel frame of C04040 gives found=1; the same frame of C04141 gives found=0.
- Two vsync falls 10 cycles apart during DIV -> overrun pulses once, first result still delivered correctly, next frame's sums start from 0.
- Single match at col 1023, row 767 with MIN_COUNT=1 -> glove_x=1023, glove_y=767. With GLOVE_BBOX_EN: bbox = 1023/1023/767/767.
